// File: rtl/iterative_alu.sv
// Handshaked MIPS execution unit. Logic, arithmetic and shift ops finish in one cycle.
// MUL/MULU/DIV/DIVU iterate one bit per cycle and return a HI/LO pair.
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLL, OP_SRL, OP_SRA, OP_MULU, OP_MUL, OP_DIVU, OP_DIV, OP_RSVD
    } op_t;

    state_t             r_state, w_state_nx;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_acc, r_q, r_opnd;
    logic               r_is_div, r_neg_q, r_neg_r;
    logic [WIDTH-1:0]   r_lo, r_hi;
    logic               r_ovf, r_dbz;

    logic               w_accept, w_is_mul, w_is_div, w_signed;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs;
    logic [WIDTH-1:0]   w_sum, w_diff, w_single_lo;
    logic               w_single_ovf;
    logic [WIDTH:0]     w_mul_sum, w_rem_sh;
    logic [WIDTH-1:0]   w_rem_sub;
    logic               w_fit;
    logic [WIDTH-1:0]   w_acc_nx, w_q_nx, w_fin_lo, w_fin_hi;
    logic [2*WIDTH-1:0] w_prod;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign w_accept    = in_valid & in_ready;
    assign result_lo   = r_lo;
    assign result_hi   = r_hi;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;

    assign w_is_mul = (op_t'(op) == OP_MUL)  || (op_t'(op) == OP_MULU);
    assign w_is_div = (op_t'(op) == OP_DIV)  || (op_t'(op) == OP_DIVU);
    assign w_signed = (op_t'(op) == OP_MUL)  || (op_t'(op) == OP_DIV);
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -a : a;
    assign w_b_abs  = w_b_neg ? -b : b;
    assign w_sum    = a + b;
    assign w_diff   = a - b;

    always_comb begin
        w_single_lo  = '0;
        w_single_ovf = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                w_single_lo  = w_sum;
                w_single_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: w_single_lo = w_sum;
            OP_SUB: begin
                w_single_lo  = w_diff;
                w_single_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: w_single_lo = w_diff;
            OP_AND:  w_single_lo = a & b;
            OP_OR:   w_single_lo = a | b;
            OP_XOR:  w_single_lo = a ^ b;
            OP_NOR:  w_single_lo = ~(a | b);
            OP_SLL:  w_single_lo = b << shamt;
            OP_SRL:  w_single_lo = b >> shamt;
            OP_SRA:  w_single_lo = $signed(b) >>> shamt;
            default: ;
        endcase
    end

    // Shared iteration registers: r_acc = product high / partial remainder,
    // r_q = multiplier / dividend shifting into quotient, r_opnd = multiplicand / divisor.
    assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : '0);
    assign w_rem_sh  = {r_acc, r_q[WIDTH-1]};
    assign w_fit     = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opnd;

    always_comb begin
        w_acc_nx = r_is_div ? (w_fit ? w_rem_sub : w_rem_sh[WIDTH-1:0]) : w_mul_sum[WIDTH:1];
        w_q_nx   = r_is_div ? {r_q[WIDTH-2:0], w_fit} : {w_mul_sum[0], r_q[WIDTH-1:1]};
        w_prod   = r_neg_q ? -{w_acc_nx, w_q_nx} : {w_acc_nx, w_q_nx};
        w_fin_lo = w_prod[WIDTH-1:0];
        w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            w_fin_lo = r_neg_q ? -w_q_nx : w_q_nx;
            w_fin_hi = r_neg_r ? -w_acc_nx : w_acc_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (w_accept)
                        w_state_nx = ((w_is_mul || w_is_div) && !(w_is_div && b == '0)) ? S_BUSY : S_DONE;
            S_BUSY: if (r_cnt == CW'(1)) w_state_nx = S_DONE;
            S_DONE: if (out_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    if (w_is_div && b == '0) begin
                        r_lo  <= '1;
                        r_hi  <= a;
                        r_ovf <= 1'b0;
                        r_dbz <= 1'b1;
                    end else if (w_is_mul || w_is_div) begin
                        r_cnt    <= CW'(WIDTH);
                        r_is_div <= w_is_div;
                        r_acc    <= '0;
                        r_opnd   <= w_is_div ? w_b_abs : w_a_abs;
                        r_q      <= w_is_div ? w_a_abs : w_b_abs;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                    end else begin
                        r_lo  <= w_single_lo;
                        r_hi  <= '0;
                        r_ovf <= w_single_ovf;
                        r_dbz <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    if (r_cnt == CW'(1)) begin
                        r_lo  <= w_fin_lo;
                        r_hi  <= w_fin_hi;
                        r_ovf <= 1'b0;
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Parametrised, handshaked execution unit for the MIPS datapath, replacing the purely combinational ALU. Single-cycle logic, arithmetic and shift ops complete in one cycle; MUL/MULU/DIV/DIVU run iteratively over WIDTH cycles and produce a HI/LO pair. It sits between operand selection (rs/rt/imm/PC muxes) and register write-back, and stalls the issue stage via a valid/ready handshake.

## Interface

- WIDTH, 32, operand/result width in bits (≥ 4, even)
- SHW, $clog2(WIDTH), shift-amount width

- clk  in  1  rising-edge clock
- rst_b  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept; transfer when in_valid & in_ready
- op  in  4  operation code (below)
- a  in  WIDTH  operand A (rs or PC)
- b  in  WIDTH  operand B (rt or extended imm)
- shamt  in  SHW  shift amount for SLL/SRL/SRA
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer takes result; transfer when out_valid & out_ready
- result_lo  out  WIDTH  main result / product low / quotient
- result_hi  out  WIDTH  product high / remainder; 0 for non-mul/div ops
- overflow  out  1  signed overflow (ADD, SUB only)
- div_by_zero  out  1  DIV/DIVU with b == 0

## Operation

- Op codes: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLL, 9 SRL, 10 SRA, 11 MULU, 12 MUL, 13 DIVU, 14 DIV, 15 reserved (result 0, flags 0).
- Arithmetic modulo 2^WIDTH; ADD/SUB set overflow on signed overflow but result still returned; ADDU/SUBU never flag.
- Shifts operate on b by shamt; SRA replicates b[WIDTH-1].
- MULU/MUL: full 2·WIDTH-bit product, {result_hi, result_lo}; MUL two's-complement signed. Shift-add, one bit per cycle.
- DIVU/DIV: restoring division, one quotient bit per cycle; lo = quotient, hi = remainder. Signed: quotient truncates toward zero, remainder takes sign of a. DIV of MIN by −1: lo = MIN, hi = 0, no flag.
- Divide by zero: lo = all ones, hi = a, div_by_zero = 1; skips iteration.
- FSM: IDLE (in_ready=1) → on accept: single-cycle op or b==0 divide → DONE; mul/div → BUSY with counter = WIDTH. BUSY decrements each cycle; at counter reaching 1 → DONE. DONE (out_valid=1) → IDLE on out_ready.
- Operands and op are captured at accept; input changes afterwards have no effect.

## Timing

- Reset (async, rst_b low): state IDLE, counter 0, in_ready 1 after release (0 while in reset is not required; in_ready is 1 in reset), out_valid 0, result_lo 0, result_hi 0, overflow 0, div_by_zero 0.
- Single-cycle op accepted at edge N: out_valid high after edge N+1.
- MUL/DIV accepted at edge N: out_valid high after edge N+WIDTH+1.
- Results and flags stable while out_valid = 1 and out_ready = 0.
- in_ready is 0 in BUSY and DONE; new op accepted only after the DONE→IDLE edge; peak throughput one op per 2 cycles.
- out_valid & out_ready at edge M: out_valid low after M; outputs retain last values until next completion.
- rst_b asserted mid-BUSY or mid-DONE: computation discarded, outputs to reset values immediately.

## Test plan

- Reset: assert rst_b=0 mid-DIV → out_valid=0, results 0, in_ready=1 after release; next ADD 5+7 → lo=12.
- ADD 0x7FFFFFFF+1 → lo=0x80000000, overflow=1, latency 1; ADDU same operands → overflow=0.
- SRA b=0x80000000 shamt=4 → 0xF8000000; SLL b=1 shamt=31 → 0x80000000; NOR 0,0 → 0xFFFFFFFF.
- MUL a=−3 b=7 → hi=0xFFFFFFFF lo=0xFFFFFFEB, out_valid exactly 33 cycles after accept; MULU 0xFFFFFFFF² → hi=0xFFFFFFFE lo=1.
- DIV a=−7 b=2 → lo=−3, hi=−1; DIVU a=100 b=0 → lo=0xFFFFFFFF hi=100 div_by_zero=1 latency 1; DIV 0x80000000/−1 → lo=0x80000000 hi=0.
- Backpressure: hold out_ready=0 ten cycles after completion → results stable, in_ready=0, in_valid ignored; release → one transfer, then IDLE.
